// File: rtl/fetch_decode_alu.sv
// ---------------------------------------------------------------------------
// fetch_decode_alu
//   Fetch/decode/execute slice of the MIPS-subset datapath. Holds the
//   instruction ROM (icache, fillable at run time), the instruction register,
//   a purely combinational decoder and the 32-bit ALU. Branch outcome is
//   resolved here from the ALU zero flag.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   pc                      fetch byte address
//   fill_en/addr/data       icache write port (synchronous)
//   instruction             instruction register (IR)
//   address_s1/s2/d         rs, rt, destination register numbers
//   immediate               decoded immediate
//   alu_opcode              ALU operation code (also drives the local ALU)
//   ALUSrc .. isByte        control signals for the rest of the datapath
//   in_s1, in_s2            ALU operands
//   res, zero               ALU result and zero flag
// ---------------------------------------------------------------------------
module fetch_decode_alu #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h80020000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data,
    output logic [31:0] instruction,
    output logic [4:0]  address_s1,
    output logic [4:0]  address_s2,
    output logic [4:0]  address_d,
    output logic [31:0] immediate,
    output logic [5:0]  alu_opcode,
    output logic        ALUSrc,
    output logic        readwrite,
    output logic        MemEnable,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        isByte,
    input  logic [31:0] in_s1,
    input  logic [31:0] in_s2,
    output logic [31:0] res,
    output logic        zero
);

    localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] BASE_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LB    = 6'h20;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SB    = 6'h28;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // ALU operation codes (equal to the R-type funct values, plus lui)
    localparam logic [5:0] ALU_SLLV = 6'h04;
    localparam logic [5:0] ALU_SRLV = 6'h06;
    localparam logic [5:0] ALU_SRAV = 6'h07;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_ADDU = 6'h21;
    localparam logic [5:0] ALU_SUB  = 6'h22;
    localparam logic [5:0] ALU_SUBU = 6'h23;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_NOR  = 6'h27;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_SLTU = 6'h2B;
    localparam logic [5:0] ALU_LUI  = 6'h3C;

    // -----------------------------------------------------------------------
    // Icache storage and address mapping
    // -----------------------------------------------------------------------
    logic [31:0]   icache [DEPTH];

    logic [29:0]   fetch_off;
    logic          fetch_hit;
    logic [AW-1:0] fetch_idx;
    logic [29:0]   fill_off;
    logic          fill_hit;
    logic [AW-1:0] fill_idx;
    logic          unused_byte_bits;

    // Byte-offset bits never select anything; addresses outside the window
    // (below the base or past the last word) miss.
    assign unused_byte_bits = ^{pc[1:0], fill_addr[1:0]};

    assign fetch_off = pc[31:2] - BASE_WORD;
    assign fetch_hit = (pc[31:2] >= BASE_WORD) && (fetch_off < DEPTH_WORDS);
    assign fetch_idx = fetch_off[AW-1:0];

    assign fill_off  = fill_addr[31:2] - BASE_WORD;
    assign fill_hit  = (fill_addr[31:2] >= BASE_WORD) && (fill_off < DEPTH_WORDS);
    assign fill_idx  = fill_off[AW-1:0];

    // Icache is not reset so program contents survive a core reset.
    always_ff @(posedge clock) begin
        if (fill_en && fill_hit) begin
            icache[fill_idx] <= fill_data;
        end
    end

    // IR samples the old icache word when a fill targets the same word on
    // the same edge, because both updates are non-blocking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction <= 32'h0;
        end else if (fetch_hit) begin
            instruction <= icache[fetch_idx];
        end else begin
            instruction <= 32'h0;
        end
    end

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        writes_reg;
    logic        is_beq;
    logic        is_bne;

    assign opcode     = instruction[31:26];
    assign funct      = instruction[5:0];
    assign address_s1 = instruction[25:21];
    assign address_s2 = instruction[20:16];
    assign address_d  = (opcode == OPC_RTYPE) ? instruction[15:11] : instruction[20:16];
    assign imm_sext   = {{16{instruction[15]}}, instruction[15:0]};
    assign imm_zext   = {16'h0, instruction[15:0]};

    // Everything defaults to a NOP with an add on the ALU; each opcode only
    // raises the controls it needs.
    always_comb begin
        alu_opcode = ALU_ADD;
        immediate  = 32'h0;
        ALUSrc     = 1'b0;
        readwrite  = 1'b0;
        MemEnable  = 1'b0;
        MemtoReg   = 1'b0;
        writes_reg = 1'b0;
        Jump       = 1'b0;
        isByte     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
                    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
                    ALU_SLLV, ALU_SRLV, ALU_SRAV: begin
                        alu_opcode = funct;
                        writes_reg = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            OPC_ADDI, OPC_ADDIU: begin
                alu_opcode = (opcode == OPC_ADDI) ? ALU_ADD : ALU_ADDU;
                immediate  = imm_sext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_SLTI, OPC_SLTIU: begin
                alu_opcode = (opcode == OPC_SLTI) ? ALU_SLT : ALU_SLTU;
                immediate  = imm_sext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_ANDI: begin
                alu_opcode = ALU_AND;
                immediate  = imm_zext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_ORI: begin
                alu_opcode = ALU_OR;
                immediate  = imm_zext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_XORI: begin
                alu_opcode = ALU_XOR;
                immediate  = imm_zext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_LUI: begin
                alu_opcode = ALU_LUI;
                immediate  = imm_zext;
                ALUSrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OPC_LW, OPC_LB: begin
                immediate  = imm_sext;
                ALUSrc     = 1'b1;
                MemEnable  = 1'b1;
                MemtoReg   = 1'b1;
                writes_reg = 1'b1;
                isByte     = (opcode == OPC_LB);
            end
            OPC_SW, OPC_SB: begin
                immediate  = imm_sext;
                ALUSrc     = 1'b1;
                MemEnable  = 1'b1;
                readwrite  = 1'b1;
                isByte     = (opcode == OPC_SB);
            end
            OPC_BEQ, OPC_BNE: begin
                // Branch offset is a word offset, returned as a byte offset.
                alu_opcode = ALU_SUB;
                immediate  = {imm_sext[29:0], 2'b00};
                is_beq     = (opcode == OPC_BEQ);
                is_bne     = (opcode == OPC_BNE);
            end
            OPC_J: begin
                immediate  = {6'h0, instruction[25:0]};
                Jump       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Writes to $0 are suppressed here so the regfile never sees them.
    assign RegWrite = writes_reg && (address_d != 5'd0);
    assign Branch   = (is_beq && zero) || (is_bne && !zero);

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic [4:0] shamt;
    assign shamt = in_s1[4:0];

    // Signed and unsigned add/sub share one adder; nothing traps on overflow.
    always_comb begin
        res = 32'h0;
        case (alu_opcode)
            ALU_ADD, ALU_ADDU: res = in_s1 + in_s2;
            ALU_SUB, ALU_SUBU: res = in_s1 - in_s2;
            ALU_AND:           res = in_s1 & in_s2;
            ALU_OR:            res = in_s1 | in_s2;
            ALU_XOR:           res = in_s1 ^ in_s2;
            ALU_NOR:           res = ~(in_s1 | in_s2);
            ALU_SLT:           res = {31'h0, ($signed(in_s1) < $signed(in_s2))};
            ALU_SLTU:          res = {31'h0, (in_s1 < in_s2)};
            ALU_SLLV:          res = in_s2 << shamt;
            ALU_SRLV:          res = in_s2 >> shamt;
            ALU_SRAV:          res = $unsigned($signed(in_s2) >>> shamt);
            ALU_LUI:           res = {in_s2[15:0], 16'h0};
            default:           res = 32'h0;
        endcase
    end

    assign zero = (res == 32'h0);

endmodule

// File: tb/tb_fetch_decode_alu.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_alu
//   Directed bench for fetch_decode_alu: loads instructions through the fill
//   port, fetches them into IR and compares decode/ALU outputs against
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_decode_alu;

    localparam logic [31:0] BASE = 32'h80020000;
    localparam int          DEPTH = 1024;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        fill_en;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic [31:0] instruction;
    logic [4:0]  address_s1;
    logic [4:0]  address_s2;
    logic [4:0]  address_d;
    logic [31:0] immediate;
    logic [5:0]  alu_opcode;
    logic        ALUSrc;
    logic        readwrite;
    logic        MemEnable;
    logic        MemtoReg;
    logic        RegWrite;
    logic        Branch;
    logic        Jump;
    logic        isByte;
    logic [31:0] in_s1;
    logic [31:0] in_s2;
    logic [31:0] res;
    logic        zero;

    int checks = 0;
    int errors = 0;

    fetch_decode_alu #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .pc(pc),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .instruction(instruction), .address_s1(address_s1),
        .address_s2(address_s2), .address_d(address_d),
        .immediate(immediate), .alu_opcode(alu_opcode), .ALUSrc(ALUSrc),
        .readwrite(readwrite), .MemEnable(MemEnable), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .Branch(Branch), .Jump(Jump), .isByte(isByte),
        .in_s1(in_s1), .in_s2(in_s2), .res(res), .zero(zero)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Write a word into the icache slot, then fetch it into IR on the next edge.
    task automatic applyStimulus(input logic [31:0] instr, input int slot);
        fill_en   = 1'b1;
        fill_addr = BASE + 32'(4 * slot);
        fill_data = instr;
        tick();
        fill_en   = 1'b0;
        pc        = BASE + 32'(4 * slot);
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b1;
        pc        = BASE;
        fill_en   = 1'b0;
        fill_addr = BASE;
        fill_data = 32'h0;
        in_s1     = 32'h0;
        in_s2     = 32'h0;
        tick();
        tick();
        checkOutput("reset_ir", instruction, 32'h0);
        checkOutput("reset_regwrite", {31'h0, RegWrite}, 32'h0);
        checkOutput("reset_mem", {30'h0, MemEnable, readwrite}, 32'h0);
        reset = 1'b0;

        // add $8,$9,$10 in word 0
        $display("[TB] add via fill/fetch");
        applyStimulus(32'h012A4020, 0);
        in_s1 = 32'd5;
        in_s2 = 32'd7;
        #1;
        checkOutput("add_ir", instruction, 32'h012A4020);
        checkOutput("add_rd", {27'h0, address_d}, 32'd8);
        checkOutput("add_rs", {27'h0, address_s1}, 32'd9);
        checkOutput("add_rt", {27'h0, address_s2}, 32'd10);
        checkOutput("add_regwrite", {31'h0, RegWrite}, 32'h1);
        checkOutput("add_aluop", {26'h0, alu_opcode}, 32'h20);
        checkOutput("add_res", res, 32'd12);
        checkOutput("add_zero", {31'h0, zero}, 32'h0);

        // Fill word 0 while fetching it: IR keeps the old word this edge.
        $display("[TB] read-before-write");
        fill_en   = 1'b1;
        fill_addr = BASE;
        fill_data = 32'h1022FFFF;
        pc        = BASE;
        tick();
        fill_en = 1'b0;
        checkOutput("rbw_old", instruction, 32'h012A4020);
        tick();
        checkOutput("rbw_new", instruction, 32'h1022FFFF);

        // beq $1,$2,-1
        in_s1 = 32'd3;
        in_s2 = 32'd3;
        #1;
        checkOutput("beq_zero", {31'h0, zero}, 32'h1);
        checkOutput("beq_taken", {31'h0, Branch}, 32'h1);
        checkOutput("beq_imm", immediate, 32'hFFFFFFFC);
        checkOutput("beq_alusrc", {31'h0, ALUSrc}, 32'h0);
        checkOutput("beq_regwrite", {31'h0, RegWrite}, 32'h0);
        in_s2 = 32'd4;
        #1;
        checkOutput("beq_not_taken", {31'h0, Branch}, 32'h0);

        // bne $1,$2,3
        applyStimulus(32'h14220003, 1);
        in_s1 = 32'd3;
        in_s2 = 32'd4;
        #1;
        checkOutput("bne_taken", {31'h0, Branch}, 32'h1);
        checkOutput("bne_imm", immediate, 32'h0000000C);

        // sltu / slt / srav
        applyStimulus(32'h0022182B, 1);
        in_s1 = 32'hFFFFFFFF;
        in_s2 = 32'd1;
        #1;
        checkOutput("sltu_res", res, 32'h0);
        applyStimulus(32'h0022182A, 1);
        #1;
        checkOutput("slt_res", res, 32'h1);
        applyStimulus(32'h00221807, 1);
        in_s1 = 32'd4;
        in_s2 = 32'h80000000;
        #1;
        checkOutput("srav_res", res, 32'hF8000000);

        // lw $2,-8($1)
        applyStimulus(32'h8C22FFF8, 1);
        in_s1 = 32'h00000100;
        in_s2 = 32'hFFFFFFF8;
        #1;
        checkOutput("lw_ctrl", {28'h0, MemEnable, MemtoReg, RegWrite, isByte}, 32'hE);
        checkOutput("lw_res", res, 32'h000000F8);

        // andi $2,$1,0xFFFF: zero-extended
        applyStimulus(32'h3022FFFF, 1);
        in_s1 = 32'h12345678;
        in_s2 = 32'h0000FFFF;
        #1;
        checkOutput("andi_imm", immediate, 32'h0000FFFF);
        checkOutput("andi_res", res, 32'h00005678);

        // addi $0,$1,5: write to $0 suppressed
        applyStimulus(32'h20200005, 1);
        checkOutput("addi_r0_regwrite", {31'h0, RegWrite}, 32'h0);

        // j
        applyStimulus(32'h0BFFFFFF, 1);
        checkOutput("j_jump", {31'h0, Jump}, 32'h1);
        checkOutput("j_imm", immediate, 32'h03FFFFFF);

        // Unknown opcode
        applyStimulus(32'hFC000000, 1);
        checkOutput("unk_aluop", {26'h0, alu_opcode}, 32'h20);
        checkOutput("unk_ctrl", {24'h0, ALUSrc, readwrite, MemEnable, MemtoReg,
                                 RegWrite, Branch, Jump, isByte}, 32'h0);

        // sb $2,4($1)
        applyStimulus(32'hA0220004, 1);
        checkOutput("sb_ctrl", {27'h0, MemEnable, readwrite, isByte, RegWrite, MemtoReg},
                    32'h1C);

        // lui $3,0x1234
        applyStimulus(32'h3C031234, 1);
        in_s2 = immediate;
        #1;
        checkOutput("lui_alusrc", {31'h0, ALUSrc}, 32'h1);
        checkOutput("lui_imm", immediate, 32'h00001234);
        checkOutput("lui_res", res, 32'h12340000);

        // Asynchronous reset mid-cycle, away from any edge
        $display("[TB] async reset");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_ir", instruction, 32'h0);
        checkOutput("async_reset_ctrl", {24'h0, ALUSrc, readwrite, MemEnable, MemtoReg,
                                         RegWrite, Branch, Jump, isByte}, 32'h0);
        tick();
        reset = 1'b0;

        // Out-of-range fill must not alias onto word 0
        fill_en   = 1'b1;
        fill_addr = BASE + 32'(4 * DEPTH);
        fill_data = 32'hDEADBEEF;
        pc        = BASE;
        tick();
        fill_en = 1'b0;
        checkOutput("icache_kept", instruction, 32'h1022FFFF);
        tick();
        checkOutput("oob_fill_ignored", instruction, 32'h1022FFFF);

        // Out-of-range fetches return zero
        pc = BASE + 32'(4 * DEPTH);
        tick();
        checkOutput("oob_fetch_high", instruction, 32'h0);
        applyStimulus(32'h3C031234, 1);
        pc = BASE - 32'd4;
        tick();
        checkOutput("oob_fetch_low", instruction, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
